// File: rtl/adder_bist.sv
// LFSR-driven self-test for a WIDTH-bit adder: drives operands, checks {co,s} one cycle later, counts results.
// Latency: 2 cycles per vector, done pulses 2N+2 cycles after start; no backpressure, the adder must settle in one clock.
module adder_bist #(
  parameter int unsigned WIDTH = 16,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      num_vectors,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             ci_out,
  input  logic [WIDTH-1:0] s_in,
  input  logic             co_in,
  output logic             busy,
  output logic             done,
  output logic [31:0]      correct_cnt,
  output logic [31:0]      wrong_cnt,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_ci,
  output logic [WIDTH:0]   fail_got
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'h0000_0001 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_WRAP,
    ST_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   lfsr;
  logic [31:0]   lfsr_step;
  logic [31:0]   nvec;
  logic [31:0]   idx;
  logic [31:0]   idx_inc;
  logic [WIDTH:0] ref_sum;
  logic [WIDTH:0] got;

  assign lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'd0);
  assign idx_inc   = idx + 32'd1;
  assign ref_sum   = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, ci_out};
  assign got       = {co_in, s_in};

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // ST_WRAP gives every run one settling cycle before the done pulse, so
  // an empty run and a full run share the same end-of-run overhead.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (num_vectors != 32'd0) ? ST_DRIVE : ST_WRAP;
      ST_DRIVE: state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (idx_inc == nvec) ? ST_WRAP : ST_DRIVE;
      ST_WRAP:  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lfsr        <= 32'd0;
      nvec        <= 32'd0;
      idx         <= 32'd0;
      a_out       <= '0;
      b_out       <= '0;
      ci_out      <= 1'b0;
      correct_cnt <= 32'd0;
      wrong_cnt   <= 32'd0;
      fail_valid  <= 1'b0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_ci     <= 1'b0;
      fail_got    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            lfsr        <= SEED_EFF;
            nvec        <= num_vectors;
            idx         <= 32'd0;
            correct_cnt <= 32'd0;
            wrong_cnt   <= 32'd0;
            fail_valid  <= 1'b0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_ci     <= 1'b0;
            fail_got    <= '0;
          end
        end
        ST_DRIVE: begin
          a_out  <= lfsr[WIDTH-1:0];
          b_out  <= lfsr[WIDTH+15:16];
          ci_out <= ^lfsr;
          lfsr   <= lfsr_step;
        end
        ST_CHECK: begin
          idx <= idx_inc;
          if (got == ref_sum) begin
            correct_cnt <= correct_cnt + 32'd1;
          end else begin
            wrong_cnt <= wrong_cnt + 32'd1;
            // Only the first failure of a run is kept.
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= a_out;
              fail_b     <= b_out;
              fail_ci    <= ci_out;
              fail_got   <= got;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist: 16-bit and 8-bit instances with a behavioural adder that can be faulted.
module tb_adder_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic        start16, busy16, done16, ci16, co16, fv16, fci16;
  logic [31:0] nv16, cc16, wc16;
  logic [15:0] a16, b16, s16, fa16, fb16;
  logic [16:0] fg16, sum16;
  logic [1:0]  fault16;

  logic        start8, busy8, done8, ci8, co8, fv8, fci8, fault8;
  logic [31:0] nv8, cc8, wc8;
  logic [7:0]  a8, b8, s8, fa8, fb8;
  logic [8:0]  fg8, sum8;

  adder_bist #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .num_vectors(nv16),
    .a_out(a16), .b_out(b16), .ci_out(ci16), .s_in(s16), .co_in(co16),
    .busy(busy16), .done(done16), .correct_cnt(cc16), .wrong_cnt(wc16),
    .fail_valid(fv16), .fail_a(fa16), .fail_b(fb16), .fail_ci(fci16), .fail_got(fg16)
  );

  adder_bist #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .num_vectors(nv8),
    .a_out(a8), .b_out(b8), .ci_out(ci8), .s_in(s8), .co_in(co8),
    .busy(busy8), .done(done8), .correct_cnt(cc8), .wrong_cnt(wc8),
    .fail_valid(fv8), .fail_a(fa8), .fail_b(fb8), .fail_ci(fci8), .fail_got(fg8)
  );

  // Adder under test: 1 = S bit 0 stuck at 1, 2 = S bit 0 inverted.
  always_comb begin
    sum16 = {1'b0, a16} + {1'b0, b16} + {16'd0, ci16};
    case (fault16)
      2'd1:    sum16[0] = 1'b1;
      2'd2:    sum16[0] = ~sum16[0];
      default: ;
    endcase
    co16 = sum16[16];
    s16  = sum16[15:0];
  end

  // 8-bit adder with optional Co stuck at 0.
  always_comb begin
    sum8 = {1'b0, a8} + {1'b0, b8} + {8'd0, ci8};
    s8   = sum8[7:0];
    co8  = fault8 ? 1'b0 : sum8[8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [63:0] fold(input logic [63:0] h, input logic [15:0] a,
                                       input logic [15:0] b, input logic ci);
    return {h[62:0], h[63]} ^ {31'd0, ci, b, a};
  endfunction

  function automatic logic [63:0] model_hash(input int n);
    logic [31:0] l;
    logic [63:0] h;
    l = 32'h1;
    h = 64'd0;
    for (int i = 0; i < n; i++) begin
      h = fold(h, l[15:0], l[31:16], ^l);
      l = step(l);
    end
    return h;
  endfunction

  function automatic int model_carries8(input int n);
    logic [31:0] l;
    logic [8:0]  s;
    int          c;
    l = 32'h1;
    c = 0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, l[7:0]} + {1'b0, l[23:16]} + {8'd0, ^l};
      if (s[8]) c++;
      l = step(l);
    end
    return c;
  endfunction

  // Runs N vectors on u16. k counts edges after the start edge; ign_at >= 0 pulses
  // start mid-run, ign_at == -2 pulses start during the done cycle.
  task automatic run16(input int n, input int ign_at, output int done_at,
                       output int busy_n, output logic [63:0] h);
    int k;
    h = 64'd0;
    done_at = -1;
    busy_n = 0;
    k = 0;
    start16 = 1'b1;
    nv16 = n;
    tick();
    start16 = 1'b0;
    nv16 = 32'd3;
    while (done_at < 0 && k < 2 * n + 20) begin
      if (busy16) busy_n++;
      if (k % 2 == 1 && k <= 2 * n - 1) h = fold(h, a16, b16, ci16);
      start16 = (k == ign_at) ? 1'b1 : 1'b0;
      if (done16) begin
        done_at = k;
        start16 = (ign_at == -2) ? 1'b1 : 1'b0;
      end
      tick();
      k++;
    end
    start16 = 1'b0;
  endtask

  int          d_at, b_n, k8, idle_bad;
  logic [63:0] h;

  initial begin
    rst = 1'b1;
    start16 = 1'b0; nv16 = 32'd0; fault16 = 2'd0;
    start8 = 1'b0;  nv8 = 32'd0;  fault8 = 1'b0;
    tick();
    tick();
    check("rst_ops16",   64'({a16, b16, ci16}), 64'd0);
    check("rst_flags16", 64'({busy16, done16, fv16}), 64'd0);
    check("rst_cnt16",   {cc16, wc16}, 64'd0);
    check("rst_fail16",  64'({fa16, fb16, fci16, fg16}), 64'd0);
    check("rst_all8",    64'({a8, b8, ci8, busy8, done8, fv8, cc8[7:0], wc8[7:0]}), 64'd0);
    rst = 1'b0;
    tick();

    // N=2, ideal adder, cycle by cycle.
    start16 = 1'b1; nv16 = 32'd2;
    tick();
    start16 = 1'b0;
    check("t0_busy", 64'({busy16, done16}), 64'b10);
    tick();
    check("v1_ops", 64'({a16, b16, ci16}), 64'({16'h0001, 16'h0000, 1'b1}));
    tick();
    check("v1_cnt", {cc16, wc16}, {32'd1, 32'd0});
    tick();
    check("v2_ops", 64'({a16, b16, ci16}), 64'({16'h0003, 16'h8020, 1'b0}));
    tick();
    check("v2_cnt_nodone", 64'({cc16, wc16[15:0], done16, busy16}), 64'({32'd2, 16'd0, 1'b0, 1'b1}));
    tick();
    check("done_t5", 64'({done16, busy16}), 64'b11);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    check("idle_after", 64'({done16, busy16}), 64'b00);
    tick();
    check("start_in_done_ignored", 64'(busy16), 64'd0);
    check("ops_hold", 64'({a16, b16, ci16, cc16}), 64'({16'h0003, 16'h8020, 1'b0, 32'd2}));

    // S bit 0 stuck at 1: vector 1 (sum 0x2) reads 0x3, vector 2 (0x8023) is unaffected.
    fault16 = 2'd1;
    run16(2, -1, d_at, b_n, h);
    check("sa1_done_at", 64'(d_at), 64'd5);
    check("sa1_cnt", {cc16, wc16}, {32'd1, 32'd1});
    check("sa1_fail", 64'({fv16, fa16, fb16, fci16, fg16}), 64'({1'b1, 16'h0001, 16'h0000, 1'b1, 17'h00003}));

    // S bit 0 inverted: both vectors fail, first capture is kept.
    fault16 = 2'd2;
    run16(2, -1, d_at, b_n, h);
    check("inv_cnt", {cc16, wc16}, {32'd0, 32'd2});
    check("inv_fail_kept", 64'({fv16, fa16, fb16, fci16, fg16}), 64'({1'b1, 16'h0001, 16'h0000, 1'b1, 17'h00003}));

    // N=0: clears previous capture, done after two busy cycles.
    fault16 = 2'd0;
    run16(0, -1, d_at, b_n, h);
    check("n0_done_at", 64'(d_at), 64'd1);
    check("n0_busy_cycles", 64'(b_n), 64'd2);
    check("n0_results", 64'({fv16, cc16[15:0], wc16[15:0]}), 64'd0);

    // Long run with a stray start mid-run.
    run16(10000, 7, d_at, b_n, h);
    check("long_done_at", 64'(d_at), 64'd20001);
    check("long_busy_cycles", 64'(b_n), 64'd20002);
    check("long_cnt", {cc16, wc16}, {32'd10000, 32'd0});
    check("long_ops_seq", h, model_hash(10000));
    run16(300, -1, d_at, b_n, h);
    check("rerun_ops_seq", h, model_hash(300));
    check("rerun_cnt", {cc16, wc16}, {32'd300, 32'd0});

    // Reset while vector 5 of 100 is on the operand ports.
    start16 = 1'b1; nv16 = 32'd100;
    tick();
    start16 = 1'b0;
    repeat (9) tick();
    check("pre_rst_busy", 64'(busy16), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ops", 64'({a16, b16, ci16}), 64'd0);
    check("abort_flags", 64'({busy16, done16, fv16}), 64'd0);
    check("abort_cnt", {cc16, wc16}, 64'd0);
    check("abort_fail", 64'({fa16, fb16, fci16, fg16}), 64'd0);
    idle_bad = 0;
    repeat (220) begin
      tick();
      if (done16 || busy16) idle_bad++;
    end
    check("abort_stays_idle", 64'(idle_bad), 64'd0);
    run16(4, -1, d_at, b_n, h);
    check("post_abort_seq", h, model_hash(4));
    check("post_abort_cnt", {cc16, wc16}, {32'd4, 32'd0});

    // WIDTH=8 with Co stuck at 0.
    fault8 = 1'b1;
    start8 = 1'b1; nv8 = 32'd1000;
    tick();
    start8 = 1'b0;
    k8 = 0;
    while (!done8 && k8 < 2100) begin
      tick();
      k8++;
    end
    check("w8_done_at", 64'(k8), 64'd2001);
    check("w8_wrong", 64'(wc8), 64'(model_carries8(1000)));
    check("w8_correct", 64'(cc8), 64'(1000 - model_carries8(1000)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
